memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Shares the single RAM port between icache and dcache. Registered grant FSM; dcache has priority.
//  dcache bursts (2-word LOAD1/LOAD2, WRITE_BACK1/2, FLUSH) hold the port via a burst counter.
//  An icache starvation counter forces the port back to the icache after STARVE_LIMIT waiting cycles.
//  Sits between the cache pair and the RAM model, in place of a purely combinational mux.
// PARAMETERS
//  MAX_BURST     4   max consecutive dcache words before grant is re-arbitrated
//  STARVE_LIMIT  8   icache wait cycles that force the next grant to icache
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   synchronous reset, active-high
//  iREN      in   1   icache read request
//  iaddr     in   32  icache word address
//  iwait     out  1   0 = icache word completes this cycle
//  iload     out  32  icache read data
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request (wins if dREN also high)
//  daddr     in   32  dcache word address
//  dstore    in   32  dcache write data
//  dwait     out  1   0 = dcache word completes this cycle
//  dload     out  32  dcache read data
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  dgrant    out  1   status: dcache currently owns port
//  ram_err   out  1   sticky: ERROR seen on a granted access
// BEHAVIOUR
//  Reset (RST high at posedge): state=IDLE, burst_cnt=0, starve_cnt=0, ram_err=0.
//   Outputs during/after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, dgrant=0.
//  States: IDLE, DGRANT, IGRANT. RAM outputs are a combinational function of state and the granted requester's inputs.
//  Completion: a word completes in the cycle where the port is granted, the request is high, and ramstate==ACCESS.
//   In that cycle the owner's wait is 0 and its load = ramload. Non-owner wait=1 and load=0 always.
//  Arbitration latency: request seen in IDLE -> grant on next cycle. Minimum per-word latency is 2 cycles.
//  IDLE:
//   - starve_cnt==STARVE_LIMIT & iREN -> IGRANT.
//   - else dREN|dWEN -> DGRANT, burst_cnt=0.
//   - else iREN -> IGRANT.
//   - else stay in IDLE.
//  DGRANT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN; ramstore=dstore.
//   - On completion, if d still requesting next cycle is not checked: decide on current signals.
//   - Stay in DGRANT (burst_cnt+1) if burst_cnt<MAX_BURST-1 and starve_cnt<STARVE_LIMIT.
//   - Otherwise: iREN -> IGRANT (burst_cnt=0); else -> IDLE.
//   - dREN=dWEN=0 without completion (abort) -> IDLE. RAM strobes drop that cycle.
//  IGRANT: ramaddr=iaddr; ramREN=1; ramWEN=0.
//   - On completion: dREN|dWEN -> DGRANT; else -> IDLE.
//   - iREN dropped -> IDLE.
//  starve_cnt:
//   - +1 per cycle with iREN=1 and state!=IGRANT, saturating at STARVE_LIMIT.
//   - Cleared on icache completion, or when iREN=0.
//  burst_cnt: width clog2(MAX_BURST). Cleared on every entry to DGRANT. Never wraps.
//  ERROR: ramstate=ERROR on a granted access -> no completion (wait stays 1), ram_err<=1 (sticky until RST).
//  BUSY/FREE while granted: hold grant, wait=1, strobes held.
//  RST mid-access: strobes drop in the reset cycle; any in-flight word is abandoned.
// TESTING
//  - Reset: RST=1 two cycles -> ramREN=ramWEN=0, iwait=dwait=1, dgrant=0.
//  - Simultaneous request: iREN=1, dREN=1 in IDLE -> dgrant=1 next cycle; ACCESS returns dload=ramload,
//    dwait=0; icache is granted after the dcache word.
//  - dcache 2-word write-back: dWEN held; ACCESS on cycles 2 and 4 (iREN=0) -> both words complete in DGRANT,
//    then IDLE; ramaddr follows daddr 0x100, 0x104.
//  - Starvation: dWEN held continuously, iREN=1, MAX_BURST=4 -> after 4 dcache words, IGRANT;
//    iwait=0 on the next ACCESS, iload=ramload.
//  - dREN=dWEN=1 together -> ramWEN=1, ramREN=0.
//  - ERROR: ramstate=3 during IGRANT -> iwait stays 1, ram_err=1 and remains 1 after a later ACCESS;
//    cleared only by RST.

Source files
------------

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - registered-grant arbiter sharing one RAM port between icache and dcache
//
// Purpose:
//   Grants the single RAM port to either the dcache (priority) or the icache.
//   A dcache tenure lasts at most MAX_BURST words. An icache that has waited
//   STARVE_LIMIT cycles ends the current dcache tenure at its next word, or takes the port from IDLE.
//   RAM-side outputs are combinational from the grant state and the owner's
//   request; all of them are forced idle while RST is high.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   iREN, iaddr              icache read request / word address
//   iwait, iload             icache: 0 = word completes this cycle / read data
//   dREN, dWEN               dcache read / write request (write wins)
//   daddr, dstore            dcache word address / write data
//   dwait, dload             dcache: 0 = word completes this cycle / read data
//   ramREN, ramWEN           RAM read / write strobes
//   ramaddr, ramstore        RAM address / write data
//   ramload, ramstate        RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   dgrant                   dcache currently owns the port
//   ram_err                  sticky: ERROR seen on a granted access

module memory_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        dgrant,
    output logic        ram_err
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t          state;
    logic [BW-1:0]   burst_cnt;
    logic [SW-1:0]   starve_cnt;

    logic d_req;
    logic d_own;
    logic i_own;
    logic d_done;
    logic i_done;
    logic starved;
    logic burst_more;

    assign d_req   = dREN | dWEN;
    // Ownership is masked by RST so the strobes drop in the reset cycle itself.
    assign d_own   = (state == DGRANT) && !RST;
    assign i_own   = (state == IGRANT) && !RST;
    assign d_done  = d_own && d_req && (ramstate == RS_ACCESS);
    assign i_done  = i_own && iREN  && (ramstate == RS_ACCESS);
    // starve_cnt saturates, so equality is the same as "reached the limit".
    assign starved = (starve_cnt == SW'(STARVE_LIMIT));
    // Another dcache word may follow in this tenure only if the burst has room
    // and the icache is not yet starving.
    assign burst_more = (burst_cnt < BW'(MAX_BURST - 1)) && !starved;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = !i_done;
        iload    = i_done ? ramload : 32'd0;
        dwait    = !d_done;
        dload    = d_done ? ramload : 32'd0;
        dgrant   = d_own;
        if (d_own) begin
            ramaddr  = daddr;
            ramWEN   = dWEN;
            ramREN   = dREN && !dWEN;
            ramstore = dstore;
        end else if (i_own) begin
            ramaddr  = iaddr;
            ramREN   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            starve_cnt <= '0;
            ram_err    <= 1'b0;
        end else begin
            if (((state == DGRANT) && d_req || (state == IGRANT) && iREN) &&
                (ramstate == RS_ERROR)) begin
                ram_err <= 1'b1;
            end

            if (!iREN || i_done) begin
                starve_cnt <= '0;
            end else if ((state != IGRANT) && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                IDLE: begin
                    if (starved && iREN) begin
                        state <= IGRANT;
                    end else if (d_req) begin
                        state     <= DGRANT;
                        burst_cnt <= '0;
                    end else if (iREN) begin
                        state <= IGRANT;
                    end
                end
                DGRANT: begin
                    if (d_done) begin
                        if (burst_more) begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end else begin
                            burst_cnt <= '0;
                            state     <= iREN ? IGRANT : IDLE;
                        end
                    end else if (!d_req) begin
                        state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (i_done) begin
                        if (d_req) begin
                            state     <= DGRANT;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!iREN) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
